// File: rtl/cv32e40x_aes_mask_rng_pkg.sv
// Shared types and constants for the AES32 masking-randomness source.
`timescale 1ns/1ps
package cv32e40x_aes_mask_rng_pkg;

  localparam int unsigned X_WIDTH         = 32;
  localparam int unsigned RND_WIDTH       = 26;
  localparam int unsigned MASK_B_WIDTH    = 8;
  localparam int unsigned REMASK_WIDTH    = RND_WIDTH - MASK_B_WIDTH;
  localparam logic [X_WIDTH-1:0] ZERO_SEED_SUBST = 32'h0000_0001;

  typedef enum logic [1:0] {
    ST_UNSEEDED,
    ST_WARMUP,
    ST_RUN
  } rng_state_e;

  // Layout of the AES unit's randombits operand
  typedef struct packed {
    logic [REMASK_WIDTH-1:0] remask;
    logic [MASK_B_WIDTH-1:0] mask_b;
  } rnd_word_t;

endpackage

// File: rtl/cv32e40x_xorshift32.sv
// Single combinational xorshift32 step (13, 17, 5).
`timescale 1ns/1ps
module cv32e40x_xorshift32
  import cv32e40x_aes_mask_rng_pkg::*;
(
  input  logic [X_WIDTH-1:0] x_i,
  output logic [X_WIDTH-1:0] x_o
);

  logic [X_WIDTH-1:0] s1;
  logic [X_WIDTH-1:0] s2;

  always_comb begin
    s1  = x_i ^ (x_i << 13);
    s2  = s1 ^ (s1 >> 17);
    x_o = s2 ^ (s2 << 5);
  end

endmodule

// File: rtl/cv32e40x_aes_mask_rng.sv
// Seeded xorshift32 mask source for the protected AES32 unit; one fresh word per
// accepted instruction, with warm-up after seeding and a reseed request counter.
`timescale 1ns/1ps
module cv32e40x_aes_mask_rng
  import cv32e40x_aes_mask_rng_pkg::*;
#(
  parameter int unsigned WARMUP_STEPS    = 2,
  parameter int unsigned RESEED_INTERVAL = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 seed_valid_i,
  input  logic [X_WIDTH-1:0]   seed_i,
  input  logic                 consume_i,
  output logic [RND_WIDTH-1:0] rnd_o,
  output logic                 rnd_valid_o,
  output logic                 reseed_req_o,
  output logic                 err_o
);

  // Keep the warm-up counter at least one bit wide when warm-up is disabled
  localparam int unsigned WARM_W = (WARMUP_STEPS > 0) ? $clog2(WARMUP_STEPS + 1) : 1;
  localparam int unsigned CONS_W = $clog2(RESEED_INTERVAL + 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_STEPS - 1);
  localparam logic [CONS_W-1:0] CONS_MAX  = CONS_W'(RESEED_INTERVAL);

  rng_state_e          state_q, state_d;
  logic [X_WIDTH-1:0]  x_q, x_d, x_step;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic [CONS_W-1:0]   cons_q, cons_d;
  logic                err_q, err_d;
  rnd_word_t           rnd;

  cv32e40x_xorshift32 u_step (
    .x_i (x_q),
    .x_o (x_step)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_UNSEEDED;
      x_q     <= '0;
      warm_q  <= '0;
      cons_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      warm_q  <= warm_d;
      cons_q  <= cons_d;
      err_q   <= err_d;
    end
  end

  // Seed load overrides every other action in the cycle it arrives
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    warm_d  = warm_q;
    cons_d  = cons_q;
    err_d   = err_q;
    if (seed_valid_i) begin
      x_d     = (seed_i == '0) ? ZERO_SEED_SUBST : seed_i;
      warm_d  = '0;
      cons_d  = '0;
      err_d   = 1'b0;
      state_d = (WARMUP_STEPS == 0) ? ST_RUN : ST_WARMUP;
    end else begin
      unique case (state_q)
        ST_UNSEEDED: begin
          if (consume_i) err_d = 1'b1;
        end
        ST_WARMUP: begin
          x_d    = x_step;
          warm_d = warm_q + WARM_W'(1);
          if (consume_i) err_d = 1'b1;
          if (warm_q == WARM_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (consume_i) begin
            x_d = x_step;
            if (cons_q != CONS_MAX) cons_d = cons_q + CONS_W'(1);
          end
        end
        default: state_d = ST_UNSEEDED;
      endcase
    end
  end

  always_comb begin
    rnd = '0;
    if (state_q == ST_RUN) rnd = x_q[RND_WIDTH-1:0];
  end

  assign rnd_o        = rnd;
  assign rnd_valid_o  = (state_q == ST_RUN);
  assign reseed_req_o = (cons_q == CONS_MAX);
  assign err_o        = err_q;

endmodule
